io_sw: RTL and testbench

Memory-mapped slide-switch input device for the pipelined processor's I/O bus, the input-side counterpart of the LED output register. It synchronizes and debounces the board switches, holds the debounced value in a read-only data register, and reports changes through a control/status register with ready, overrun and interrupt-enable bits. It sits on the shared `addrbus`/`databus` and drives `databus` only when its own addresses are read.

---
 rtl/io_sw_if.sv | 17 +
 rtl/io_sw.sv | 128 ++++++++++++
 tb/tb_io_sw.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_sw_if.sv
// io_sw_if: address/strobe half of the shared I/O bus.
//   wrtEn   - write strobe (1 = write cycle, 0 = read cycle)
//   addrbus - bus address
// The data bus itself is a shared tristate net. It is connected to the
// device as a plain inout port so that every bus agent resolves the same net.
// Handshake: there is no valid/ready pair. Every clock cycle is one bus cycle.
// The master holds wrtEn/addrbus for the whole cycle. A read returns data
// combinationally in that same cycle. A write takes effect at the closing edge.
interface io_sw_if #(
    parameter int DATA_BIT_WIDTH = 32
);
    logic                      wrtEn;
    logic [DATA_BIT_WIDTH-1:0] addrbus;

    modport master (output wrtEn, output addrbus);
    modport slave  (input  wrtEn, input  addrbus);
endinterface

// File: rtl/io_sw.sv
// io_sw: memory-mapped slide-switch input device.
// It synchronizes and debounces the switches and holds the accepted value in
// the read-only SDATA register. It reports new values through SCTRL:
//   bit0 = RDY, bit2 = OVR, bit8 = IE.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   bus        - io_sw_if slave (wrtEn, addrbus)
//   databus    - shared tristate data bus. It is driven only on reads of
//                DATA_ADDR or CTRL_ADDR.
//   sw         - raw asynchronous switch levels
//   intr       - interrupt request, RDY & IE
module io_sw #(
    parameter int                          DATA_BIT_WIDTH  = 32,
    parameter int                          SW_BITS         = 10,
    parameter int                          DEBOUNCE_CYCLES = 1000000,
    parameter logic [DATA_BIT_WIDTH-1:0]   DATA_ADDR       = 32'hF0000014,
    parameter logic [DATA_BIT_WIDTH-1:0]   CTRL_ADDR       = 32'hF0000114
) (
    input  logic                      clk,
    input  logic                      reset,
    io_sw_if.slave                    bus,
    inout  wire  [DATA_BIT_WIDTH-1:0] databus,
    input  logic [SW_BITS-1:0]        sw,
    output logic                      intr
);
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SW_BITS-1:0] sync1_q, sync1_d;
    logic [SW_BITS-1:0] sync2_q, sync2_d;
    logic [SW_BITS-1:0] cand_q,  cand_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [SW_BITS-1:0] sdata_q, sdata_d;
    logic               rdy_q,   rdy_d;
    logic               ovr_q,   ovr_d;
    logic               ie_q,    ie_d;

    logic                      upd_evt;
    logic                      rd_data;
    logic                      rd_ctrl;
    logic                      wr_ctrl;
    logic [DATA_BIT_WIDTH-1:0] rd_val;

    assign rd_data = (bus.addrbus == DATA_ADDR) && !bus.wrtEn;
    assign rd_ctrl = (bus.addrbus == CTRL_ADDR) && !bus.wrtEn;
    assign wr_ctrl = (bus.addrbus == CTRL_ADDR) &&  bus.wrtEn;

    // SCTRL writes only look at bits 2 and 8. The other bits are ignored.
    wire unused_wr_bits = &{1'b0, databus[DATA_BIT_WIDTH-1:9], databus[7:3], databus[1:0]};

    always_comb begin
        sync1_d = sw;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        sdata_d = sdata_q;
        rdy_d   = rdy_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;
        upd_evt = 1'b0;

        // One candidate and one counter cover the whole switch vector.
        // Any change restarts the stability count.
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cand_q != sdata_q) begin
            sdata_d = cand_q;
            upd_evt = 1'b1;
        end

        if (wr_ctrl) begin
            ie_d = databus[8];
            if (!databus[2]) begin
                ovr_d = 1'b0;
            end
        end

        // An overrun set overrides a same-cycle software clear. A read that
        // coincides with an update consumes the old value, so it is no overrun.
        if (upd_evt) begin
            rdy_d = 1'b1;
            if (rdy_q && !rd_data) begin
                ovr_d = 1'b1;
            end
        end else if (rd_data) begin
            rdy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            sdata_q <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sdata_q <= sdata_d;
            rdy_q   <= rdy_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
        end
    end

    always_comb begin
        rd_val = '0;
        if (rd_data) begin
            rd_val[SW_BITS-1:0] = sdata_q;
        end else begin
            rd_val[0] = rdy_q;
            rd_val[2] = ovr_q;
            rd_val[8] = ie_q;
        end
    end

    assign databus = (rd_data || rd_ctrl) ? rd_val : {DATA_BIT_WIDTH{1'bz}};
    assign intr    = rdy_q & ie_q;
endmodule

// File: tb/tb_io_sw.sv
module tb_io_sw;
  localparam int DW = 32;
  localparam int SWB = 10;
  localparam int DC = 4;
  localparam logic [DW-1:0] DATA_A = 32'hF0000014;
  localparam logic [DW-1:0] CTRL_A = 32'hF0000114;
  localparam logic [DW-1:0] NONE_A = 32'hF0000004;
  localparam int K_DATA = 0;
  localparam int K_Z = 1;
  localparam int K_INTR = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic [SWB-1:0] sw;
  logic intr;
  logic [DW-1:0] tb_wdata;
  logic tb_drive;
  wire [DW-1:0] databus;

  assign databus = tb_drive ? tb_wdata : {DW{1'bz}};

  io_sw_if #(.DATA_BIT_WIDTH(DW)) bus_if ();

  io_sw #(
    .DATA_BIT_WIDTH(DW), .SW_BITS(SWB), .DEBOUNCE_CYCLES(DC),
    .DATA_ADDR(DATA_A), .CTRL_ADDR(CTRL_A)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave), .databus(databus),
    .sw(sw), .intr(intr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A value is accepted once the switch samples have held it for DC+2
  // consecutive edges. The acceptance lands two edges after the last of
  // those samples, because of the synchronizer.
  logic [SWB-1:0] hist[$];
  logic [SWB-1:0] m_sdata = '0;
  bit m_rdy = 0;
  bit m_ovr = 0;
  bit m_ie = 0;

  always @(posedge clk) begin : model
    bit rd, wr, upd, stable;
    if (reset) begin
      hist = {};
      repeat (3) hist.push_back('0);
      m_sdata = '0; m_rdy = 0; m_ovr = 0; m_ie = 0;
    end else begin
      rd = (bus_if.addrbus == DATA_A) && !bus_if.wrtEn;
      wr = (bus_if.addrbus == CTRL_A) && bus_if.wrtEn;
      hist.push_back(sw);
      if (hist.size() > DC + 4) void'(hist.pop_front());
      stable = (hist.size() == DC + 4);
      if (stable)
        for (int i = 1; i < DC + 2; i++)
          if (hist[i] != hist[0]) stable = 0;
      upd = stable && (hist[0] != m_sdata);
      if (wr && !tb_wdata[2]) m_ovr = 0;
      if (upd && m_rdy && !rd) m_ovr = 1;
      if (wr) m_ie = tb_wdata[8];
      if (upd) begin
        m_rdy = 1;
        m_sdata = hist[0];
      end else if (rd) begin
        m_rdy = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int kind_q[$];
  string name_q[$];
  bit rd_chk = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(negedge clk) begin : monitor
    int k;
    logic [DW-1:0] e;
    string nm;
    bit ok;
    if (rd_chk && kind_q.size() > 0) begin
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      case (k)
        K_DATA: ok = (databus === e);
        K_Z: ok = (databus === {DW{1'bz}});
        default: ok = (intr === e[0]);
      endcase
      if (ok) n_pass++;
      else if (k == K_INTR) $display("FAIL %s: intr got %b expected %b", nm, intr, e[0]);
      else if (k == K_Z) $display("FAIL %s: databus got %h expected high-Z", nm, databus);
      else $display("FAIL %s: databus got %h expected %h", nm, databus, e);
    end
    n_checks++;
    if (intr === (m_rdy & m_ie)) n_pass++;
    else $display("FAIL intr_model: intr got %b expected %b", intr, m_rdy & m_ie);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    rd_chk = 0;
  endtask

  task automatic cyc(input logic [DW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                     input int kind, input logic [DW-1:0] exp, input string nm);
    bus_if.addrbus = addr;
    bus_if.wrtEn = wr;
    tb_wdata = wd;
    tb_drive = wr;
    if (kind >= 0) begin
      exp_q.push_back(exp);
      kind_q.push_back(kind);
      name_q.push_back(nm);
      rd_chk = 1;
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, '0, -1, '0, "");
  endtask

  task automatic rd_data_c(input logic [DW-1:0] exp, input string nm);
    cyc(DATA_A, 1'b0, '0, K_DATA, exp, nm);
  endtask

  task automatic rd_ctrl_c(input logic [DW-1:0] exp, input string nm);
    cyc(CTRL_A, 1'b0, '0, K_DATA, exp, nm);
  endtask

  task automatic wr_ctrl(input logic [DW-1:0] wd);
    cyc(CTRL_A, 1'b1, wd, -1, '0, "");
  endtask

  task automatic chk_intr(input logic e, input string nm);
    cyc('0, 1'b0, '0, K_INTR, {31'b0, e}, nm);
  endtask

  task automatic chk_z(input string nm);
    cyc(NONE_A, 1'b0, '0, K_Z, '0, nm);
  endtask

  task automatic rd_data_m();
    cyc(DATA_A, 1'b0, '0, K_DATA, {{(DW-SWB){1'b0}}, m_sdata}, "rand_sdata");
  endtask

  task automatic rd_ctrl_m();
    cyc(CTRL_A, 1'b0, '0, K_DATA, {23'b0, m_ie, 5'b0, m_ovr, 1'b0, m_rdy}, "rand_sctrl");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    sw = '0;
    idle(3);
    reset = 1'b0;

    // reset and idle
    rd_data_c(32'h0, "rst_sdata");
    rd_ctrl_c(32'h0, "rst_sctrl");
    chk_z("unmapped_z");
    chk_intr(1'b0, "rst_intr");

    // debounce latency: cycle k sees the state after edge k-1
    sw = 10'h2A5;
    for (int i = 0; i < 7; i++) rd_data_c(32'h0, "lat_sdata_pre");
    rd_ctrl_c(32'h0, "lat_rdy_pre");
    rd_ctrl_c(32'h1, "lat_rdy_set");
    rd_data_c(32'h2A5, "lat_sdata");
    rd_ctrl_c(32'h0, "lat_rdy_clr");

    // glitch rejection from a fresh reset
    sw = '0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    sw = 10'h001;
    idle(3);
    sw = '0;
    idle(20);
    rd_data_c(32'h0, "glitch_sdata");
    rd_ctrl_c(32'h0, "glitch_sctrl");

    // overrun
    sw = 10'h001;
    idle(12);
    sw = 10'h003;
    idle(12);
    rd_ctrl_c(32'h005, "ovr_set");
    wr_ctrl(32'h000);
    rd_ctrl_c(32'h001, "ovr_clr");
    wr_ctrl(32'h004);
    rd_ctrl_c(32'h001, "ovr_w1_noeff");

    // interrupt
    wr_ctrl(32'h100);
    rd_data_c(32'h003, "int_sdata_pre");
    chk_intr(1'b0, "intr_low");
    sw = 10'h3FF;
    idle(7);
    chk_intr(1'b0, "intr_pre");
    chk_intr(1'b1, "intr_rise");
    rd_ctrl_c(32'h101, "int_sctrl");

    // update colliding with an SDATA read
    sw = 10'h155;
    idle(7);
    rd_data_c(32'h3FF, "coll_old_sdata");
    rd_ctrl_c(32'h101, "coll_sctrl");

    // overrun set beats a same-cycle clear
    sw = 10'h0AA;
    idle(7);
    wr_ctrl(32'h100);
    rd_ctrl_c(32'h105, "ovr_set_wins");

    // reset two edges before acceptance
    sw = 10'h0F0;
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) rd_data_c(32'h0, "rstmid_sdata_pre");
    rd_ctrl_c(32'h001, "rstmid_rdy");
    rd_data_c(32'h0F0, "rstmid_sdata");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) sw = SWB'($urandom_range(0, 1023));
      reset = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 7))
        0: rd_data_m();
        1: rd_ctrl_m();
        2: wr_ctrl($urandom);
        3: chk_z("rand_z");
        default: idle(1);
      endcase
    end
    reset = 1'b0;
    idle(2);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
